// File: rtl/busarb.sv
// rtl/busarb.sv - round-robin N-master arbiter driving single-ported busctl cycles
module busarb #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_MASTERS-1:0]             req_valid,
    output logic [N_MASTERS-1:0]             req_ready,
    input  logic [N_MASTERS-1:0]             req_write,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  req_wdata,
    output logic [N_MASTERS-1:0]             resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_rdata,
    output logic                             bus_en,
    output logic                             bus_write,
    output logic [ADDR_WIDTH-1:0]            bus_addr,
    output logic [DATA_WIDTH-1:0]            bus_wdata,
    input  logic [DATA_WIDTH-1:0]            bus_rdata
);

    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUS, WAIT, RESP} state_t;

    state_t                  state, state_nxt;
    logic [GW-1:0]           last_grant;
    logic [GW-1:0]           grant;
    logic [GW-1:0]           win;
    logic                    win_found;
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [CW-1:0]           lat_cnt;

    // Rotating priority: search upward from the master after the last winner.
    always_comb begin
        int          idx;
        logic [GW-1:0] idx_g;
        win       = last_grant;
        win_found = 1'b0;
        idx       = 0;
        idx_g     = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx   = (int'(last_grant) + k) % N_MASTERS;
            idx_g = GW'(idx);
            if (!win_found && req_valid[idx_g]) begin
                win       = idx_g;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        bus_en     = 1'b0;
        bus_write  = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so nothing is offered while the block is held in reset.
                if (win_found && reset) begin
                    req_ready[win] = 1'b1;
                    state_nxt      = BUS;
                end
            end
            BUS: begin
                bus_en    = 1'b1;
                bus_write = lat_write;
                state_nxt = lat_write ? RESP : WAIT;
            end
            WAIT: begin
                if (lat_cnt == CW'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid[grant] = 1'b1;
                state_nxt         = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= GW'(N_MASTERS - 1);
            grant      <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_cnt    <= '0;
            resp_rdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant      <= win;
                        last_grant <= win;
                        lat_write  <= req_write[win];
                        lat_addr   <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                        lat_wdata  <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                BUS: begin
                    lat_cnt <= CW'(RD_LATENCY);
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - CW'(1);
                    if (lat_cnt == CW'(1)) begin
                        resp_rdata <= bus_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;

endmodule

// File: tb/tb_busarb.sv
// tb/tb_busarb.sv - directed bench for busarb with two-master and four-master instances
module tb_busarb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [1:0]  a_req_valid, a_req_ready, a_req_write, a_resp_valid;
    logic [15:0] a_req_addr, a_req_wdata;
    logic [7:0]  a_resp_rdata, a_bus_addr, a_bus_wdata, a_bus_rdata;
    logic        a_bus_en, a_bus_write;

    logic [3:0]  b_req_valid, b_req_ready, b_req_write, b_resp_valid;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [7:0]  b_resp_rdata, b_bus_addr, b_bus_wdata, b_bus_rdata;
    logic        b_bus_en, b_bus_write;

    busarb #(.N_MASTERS(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(3)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .bus_en(a_bus_en), .bus_write(a_bus_write), .bus_addr(a_bus_addr),
        .bus_wdata(a_bus_wdata), .bus_rdata(a_bus_rdata)
    );

    busarb #(.N_MASTERS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .bus_en(b_bus_en), .bus_write(b_bus_write), .bus_addr(b_bus_addr),
        .bus_wdata(b_bus_wdata), .bus_rdata(b_bus_rdata)
    );

    assign b_bus_rdata = 8'h00;

    // Memory for instance a: read data (addr ^ 0x1C) is valid only in the third cycle after the bus cycle.
    logic [1:0] mem_cnt;
    logic [7:0] mem_data;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_cnt  <= 2'd0;
            mem_data <= 8'h00;
        end else if (a_bus_en && !a_bus_write) begin
            mem_cnt  <= 2'd3;
            mem_data <= a_bus_addr ^ 8'h1C;
        end else if (mem_cnt != 2'd0) begin
            mem_cnt <= mem_cnt - 2'd1;
        end
    end
    assign a_bus_rdata = (mem_cnt == 2'd1) ? mem_data : 8'hEE;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at negedge+1 of cycle A, where master 0's read of 0x40 is being accepted.
    // Master 1 raises a write during BUS and must wait until IDLE after the response.
    task automatic a_read_then_write(input logic [7:0] exp_rd, input logic [7:0] m1_addr,
                                     input logic [7:0] m1_data);
        @(posedge clk); @(negedge clk);
        a_req_valid        = 2'b10;
        a_req_write[1]     = 1'b1;
        a_req_addr[15:8]   = m1_addr;
        a_req_wdata[15:8]  = m1_data;
        #1;
        chk("rd_bus_en", a_bus_en, 1);
        chk("rd_bus_write", a_bus_write, 0);
        chk("rd_bus_addr", a_bus_addr, 8'h40);
        chk("late_ready_bus", a_req_ready, 2'b00);
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk); @(negedge clk); #1;
            chk("late_ready_wait", a_req_ready, 2'b00);
            chk("rd_resp_valid", a_resp_valid, (c == 5) ? 2'b01 : 2'b00);
            if (c == 5) chk("rd_resp_rdata", a_resp_rdata, exp_rd);
        end
        @(posedge clk); @(negedge clk); #1;
        chk("late_ready_idle", a_req_ready, 2'b10);
        @(posedge clk); @(negedge clk);
        a_req_valid = 2'b00;
        #1;
        chk("late_bus_en", a_bus_en, 1);
        chk("late_bus_write", a_bus_write, 1);
        chk("late_bus_addr", a_bus_addr, m1_addr);
        chk("late_bus_wdata", a_bus_wdata, m1_data);
        @(posedge clk); @(negedge clk); #1;
        chk("late_resp_valid", a_resp_valid, 2'b10);
        chk("late_rdata_kept", a_resp_rdata, exp_rd);
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        reset       = 1'b0;
        a_req_valid = 2'b11;
        a_req_write = 2'b11;
        a_req_addr  = {8'h12, 8'h33};
        a_req_wdata = {8'hA5, 8'h77};
        b_req_valid = 4'hF;
        b_req_write = 4'hF;
        b_req_addr  = {8'h13, 8'h12, 8'h11, 8'h10};
        b_req_wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        repeat (3) @(negedge clk);
        chk("rst_a_ready", a_req_ready, 2'b00);
        chk("rst_a_resp_valid", a_resp_valid, 2'b00);
        chk("rst_a_resp_rdata", a_resp_rdata, 8'h00);
        chk("rst_a_bus_en", a_bus_en, 0);
        chk("rst_a_bus_write", a_bus_write, 0);
        chk("rst_a_bus_addr", a_bus_addr, 8'h00);
        chk("rst_a_bus_wdata", a_bus_wdata, 8'h00);
        chk("rst_b_ready", b_req_ready, 4'h0);
        chk("rst_b_bus_en", b_bus_en, 0);
        chk("rst_b_resp_valid", b_resp_valid, 4'h0);

        reset = 1'b1;
        // Write round-robin on b; a runs master 0 then master 1's single write alongside.
        for (int k = 0; k < 6; k++) begin
            g = k % 4;
            #1;
            chk("rr_ready", b_req_ready, 1 << g);
            if (k < 2) chk("a_wr_ready", a_req_ready, 1 << k);
            @(posedge clk); @(negedge clk);
            if (k == 0) a_req_valid[0] = 1'b0;
            if (k == 1) a_req_valid[1] = 1'b0;
            #1;
            chk("rr_bus_en", b_bus_en, 1);
            chk("rr_bus_write", b_bus_write, 1);
            chk("rr_bus_addr", b_bus_addr, 8'h10 + g);
            chk("rr_bus_wdata", b_bus_wdata, 8'hA0 + g);
            chk("rr_ready_bus", b_req_ready, 4'h0);
            if (k < 2) begin
                chk("a_wr_bus_en", a_bus_en, 1);
                chk("a_wr_bus_write", a_bus_write, 1);
                chk("a_wr_bus_addr", a_bus_addr, (k == 1) ? 8'h12 : 8'h33);
                chk("a_wr_bus_wdata", a_bus_wdata, (k == 1) ? 8'hA5 : 8'h77);
            end
            @(posedge clk); @(negedge clk);
            if (k == 5) b_req_valid = 4'h0;
            #1;
            chk("rr_resp_valid", b_resp_valid, 1 << g);
            chk("rr_bus_en_resp", b_bus_en, 0);
            if (k < 2) begin
                chk("a_wr_resp_valid", a_resp_valid, 1 << k);
                chk("a_wr_ready_resp", a_req_ready, 2'b00);
                chk("a_wr_rdata", a_resp_rdata, 8'h00);
            end
            @(posedge clk); @(negedge clk);
        end
        #1;
        chk("rr_idle_ready", b_req_ready, 4'h0);

        a_req_valid      = 2'b01;
        a_req_write      = 2'b10;
        a_req_addr[7:0]  = 8'h40;
        #1;
        chk("rd_ready", a_req_ready, 2'b01);
        a_read_then_write(8'h5C, 8'h21, 8'h3C);

        a_req_valid = 2'b01;
        #1;
        chk("mrr_ready", a_req_ready, 2'b01);
        @(posedge clk); @(negedge clk);
        a_req_valid       = 2'b10;
        a_req_addr[15:8]  = 8'h55;
        a_req_wdata[15:8] = 8'h66;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrr_bus_en", a_bus_en, 0);
        chk("mrr_resp_valid", a_resp_valid, 2'b00);
        chk("mrr_resp_rdata", a_resp_rdata, 8'h00);
        chk("mrr_ready", a_req_ready, 2'b00);
        a_req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("mrr_hold_resp", a_resp_valid, 2'b00);
            chk("mrr_hold_ready", a_req_ready, 2'b00);
        end
        reset = 1'b1;
        #1;
        chk("mrr_prio_m0", a_req_ready, 2'b01);
        a_read_then_write(8'h5C, 8'h55, 8'h66);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
